// File: rtl/change_gen.sv
// change_gen: turns single-cycle event pulses into one Gray-code step each
// on x, with a minimum hold time per value and a bounded backlog.
module change_gen #(
  parameter int WIDTH    = 8,
  parameter int HOLD     = 2,
  parameter int MAX_PEND = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ev,
  output logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             ovf
);

  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [PW:0]   PEND_MAX = (PW + 1)'(MAX_PEND);
  localparam logic [HW-1:0] HOLD_TOP = HW'(HOLD - 1);

  logic [WIDTH-1:0] bin, bin_n;
  logic [PW-1:0]    pend, pend_n;
  logic [HW-1:0]    hold, hold_n;
  logic [PW:0]      eff;
  logic             emit;
  logic             drop;

  always_comb begin
    eff    = {1'b0, pend} + {{PW{1'b0}}, ev};
    emit   = (hold == '0) && (eff != '0);
    bin_n  = bin;
    pend_n = pend;
    hold_n = hold;
    drop   = 1'b0;
    if (emit) begin
      bin_n  = bin + 1'b1;
      hold_n = HOLD_TOP;
      pend_n = PW'(eff - 1'b1);
    end else begin
      if (hold != '0)
        hold_n = hold - 1'b1;
      // a full backlog with no emit this edge has nowhere to put the event
      if (eff <= PEND_MAX)
        pend_n = PW'(eff);
      else
        drop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin  <= '0;
      pend <= '0;
      hold <= '0;
      x    <= '0;
      busy <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      bin  <= bin_n;
      pend <= pend_n;
      hold <= hold_n;
      x    <= bin_n ^ (bin_n >> 1);
      busy <= (pend_n != '0) || (hold_n != '0);
      if (drop)
        ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_change_gen.sv
// tb_change_gen: directed scenarios on two instances (HOLD=3 and HOLD=1),
// expected x changes queued as stimulus is applied and popped on each change.
module tb_change_gen;

  logic       clk;
  logic       rst;
  logic       ev0;
  logic       ev1;
  logic [3:0] x0;
  logic [3:0] x1;
  logic       busy0;
  logic       busy1;
  logic       ovf0;
  logic       ovf1;

  int vec;
  int errs;
  int cyc;
  int l0;
  logic [3:0] p0;
  logic [3:0] p1;
  logic [3:0] q0[$];
  logic [3:0] q1[$];

  change_gen #(.WIDTH(4), .HOLD(3), .MAX_PEND(2)) u0 (
    .clk(clk), .rst(rst), .ev(ev0),
    .x(x0), .busy(busy0), .ovf(ovf0)
  );

  change_gen #(.WIDTH(4), .HOLD(1), .MAX_PEND(2)) u1 (
    .clk(clk), .rst(rst), .ev(ev1),
    .x(x1), .busy(busy1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] gray(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic e0, input logic e1, input logic r);
    ev0 = e0;
    ev1 = e1;
    rst = r;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      l0 = -1000;
    end else begin
      if (x0 !== p0) begin
        chk("x0_onebit", $countones(x0 ^ p0), 1);
        chk("x0_spacing", 32'(cyc - l0 >= 3), 1);
        if (q0.size() == 0) chk("x0_spurious", x0, p0);
        else chk("x0_seq", x0, q0.pop_front());
        l0 = cyc;
      end
      if (x1 !== p1) begin
        chk("x1_onebit", $countones(x1 ^ p1), 1);
        if (q1.size() == 0) chk("x1_spurious", x1, p1);
        else chk("x1_seq", x1, q1.pop_front());
      end
    end
    p0 = x0;
    p1 = x1;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b1);
    chk("rst_x0", x0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_ovf0", ovf0, 0);
    chk("rst_x1", x1, 0);
  endtask

  initial begin
    vec = 0; errs = 0; cyc = 0; l0 = -1000;
    p0 = '0; p1 = '0;
    ev0 = 1'b0; ev1 = 1'b0; rst = 1'b1;

    // 1: reset, then quiet for 20 cycles
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    chk("init_x0", x0, 0);
    chk("init_busy0", busy0, 0);
    chk("init_ovf0", ovf0, 0);
    chk("init_x1", x1, 0);
    chk("init_busy1", busy1, 0);
    chk("init_ovf1", ovf1, 0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0);
    chk("idle_x0", x0, 0);

    // 2: single event
    do_reset();
    q0.push_back(gray(1));
    tick(1'b1, 1'b0, 1'b0);
    chk("s2_x_e1", x0, 4'b0001);
    chk("s2_busy_e1", busy0, 1);
    tick(1'b0, 1'b0, 1'b0);
    chk("s2_busy_e2", busy0, 1);
    tick(1'b0, 1'b0, 1'b0);
    chk("s2_busy_e3", busy0, 0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);
    chk("s2_x_end", x0, 4'b0001);
    chk("s2_q", q0.size(), 0);

    // 3: backlog of four events
    do_reset();
    q0.push_back(4'b0001);
    q0.push_back(4'b0011);
    q0.push_back(4'b0010);
    q0.push_back(4'b0110);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
    chk("s3_busy", busy0, 1);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0);
    chk("s3_x_end", x0, 4'b0110);
    chk("s3_ovf", ovf0, 0);
    chk("s3_busy_end", busy0, 0);
    chk("s3_q", q0.size(), 0);

    // 4: fifth event overflows and is dropped
    do_reset();
    q0.push_back(4'b0001);
    q0.push_back(4'b0011);
    q0.push_back(4'b0010);
    q0.push_back(4'b0110);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
    chk("s4_ovf_e4", ovf0, 0);
    tick(1'b1, 1'b0, 1'b0);
    chk("s4_ovf_e5", ovf0, 1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);
    chk("s4_ovf_end", ovf0, 1);
    chk("s4_x_end", x0, 4'b0110);
    chk("s4_q", q0.size(), 0);

    // 5: HOLD=1 back-to-back with wrap
    do_reset();
    for (int i = 1; i <= 17; i++) q1.push_back(gray(i));
    for (int i = 1; i <= 17; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (i == 15) chk("s5_x15", x1, 4'b1000);
      if (i == 16) chk("s5_x16", x1, 4'b0000);
    end
    chk("s5_x17", x1, 4'b0001);
    chk("s5_ovf", ovf1, 0);
    tick(1'b0, 1'b0, 1'b0);
    chk("s5_busy_end", busy1, 0);
    chk("s5_q", q1.size(), 0);

    // 6: reset in the middle of a backlog
    do_reset();
    q0.push_back(4'b0001);
    q0.push_back(4'b0011);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
    chk("s6_x_e4", x0, 4'b0011);
    tick(1'b1, 1'b0, 1'b1);
    chk("s6_x_rst", x0, 0);
    chk("s6_busy_rst", busy0, 0);
    chk("s6_ovf_rst", ovf0, 0);
    chk("s6_q", q0.size(), 0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b0);
    chk("s6_x_end", x0, 0);
    chk("s6_busy_end", busy0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/change_gen.md
Name: change_gen

Overview:
- Event-to-transition encoder; the transmit-side counterpart of the change-detect pulser.
- Each 1-cycle event pulse on `ev` produces exactly one observable change on a WIDTH-bit bus `x`.
- `x` is a Gray-coded event counter, so every change flips exactly one bit. A downstream change detector therefore recovers one pulse per event.
- Enforces a minimum stable time per value, so a receiver sampling once per clock never misses or merges changes. Events arriving during the hold time are queued in a bounded pending counter.

Parameters:
- WIDTH, 8: width of `x`; legal range ≥ 2.
- HOLD, 2: minimum number of cycles `x` stays stable after each change; legal range ≥ 1.
- MAX_PEND, 4: maximum queued events not yet emitted; legal range ≥ 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ev  input  1  event request, sampled each rising edge. High on N consecutive edges = N events.
- x  output  WIDTH  registered Gray-coded event count; one bit changes per emitted event.
- busy  output  1  registered; high when pending != 0 or hold_cnt != 0.
- ovf  output  1  registered sticky overflow; set when an event is dropped, cleared only by rst.

Behaviour:
- Clocking and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: x = 0, internal binary count = 0, pending = 0, hold_cnt = 0, busy = 0, ovf = 0. Reset takes priority over `ev` in the same cycle.
- Reset mid-operation: queued events are discarded, the hold time is aborted, and `x` returns to 0 on that edge.
- Internal state:
  - bin: WIDTH-bit binary count.
  - pending: $clog2(MAX_PEND+1) bits.
  - hold_cnt: 0 .. HOLD-1.
- Output encoding: x = bin ^ (bin >> 1), registered.
- Per edge (not in reset), compute eff = pending + ev.
- Emit condition: hold_cnt == 0 and eff > 0. On an emit edge:
  - bin <= bin + 1, wrapping from 2^WIDTH-1 to 0. The Gray code wrap is also a single-bit change.
  - hold_cnt <= HOLD-1.
  - pending <= eff - 1.
- No-emit edge:
  - If hold_cnt > 0: hold_cnt <= hold_cnt - 1.
  - If eff ≤ MAX_PEND: pending <= eff.
  - Else (ev while pending == MAX_PEND): pending stays MAX_PEND, the event is dropped, and ovf <= 1.
- Simultaneous ev and emission: the event is accepted even when pending == MAX_PEND, since the emit frees one slot (net pending unchanged).
- Latency: an `ev` sampled at edge k with the block idle changes `x` at edge k, visible in the cycle after k.
- Spacing:
  - Consecutive changes are separated by at least HOLD edges.
  - Under a backlog, they are separated by exactly HOLD edges.
  - HOLD = 1: back-to-back events change `x` every cycle, and overflow is impossible.
- No change ever occurs without a corresponding accepted event. Dropped events never produce a change.
- busy is registered from next-state values: it is high on the cycle after any edge that leaves pending != 0 or hold_cnt != 0.

Test Plan:
1. Reset: hold rst for 2 edges, then release with ev = 0 → x = 0, busy = 0, ovf = 0, x stable for 20 cycles.
2. Single event (WIDTH=4, HOLD=3, MAX_PEND=2), ev high for edge 1 only:
   - x = 0001 after edge 1.
   - busy = 1 for 2 cycles after edge 1, then 0.
   - x stable ≥ 3 cycles.
3. Backlog (same params), ev high on edges 1–4:
   - x changes only at edges 1, 4, 7, 10: x = 0001, 0011, 0010, 0110.
   - pending peaks at 2; ovf = 0.
4. Overflow (same params), ev high on edges 1–5:
   - Edge-5 event dropped; ovf = 1 after edge 5 and stays 1.
   - Exactly 4 changes (edges 1, 4, 7, 10), final x = 0110.
5. Wrap and HOLD = 1 (WIDTH=4, HOLD=1), ev held high 17 edges:
   - x changes every edge: after 15 events x = 1000, 16th gives 0000, 17th gives 0001.
   - Every change is a single-bit flip; ovf = 0.
6. Reset mid-backlog: scenario 3, assert rst at edge 5 →
   - x = 0, busy = 0, ovf = 0 after edge 5.
   - No further changes after rst deasserts with ev = 0.
